// File: rtl/rf_wr_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
//   PW            : address pointer width; register addresses are PW+1 bits
//   NUM_WR_PORTS  : number of writeback requesters sharing the write port
//   PORT_LD/ALU   : requester indices, also the encoding of the round-robin pointer
//   wr_req_t      : one pending write (destination, data, ALU flags)
package rf_pkg;

  localparam int PW           = 3;
  localparam int NUM_WR_PORTS = 2;
  localparam int PORT_LD      = 0;
  localparam int PORT_ALU     = 1;

  typedef struct packed {
    logic [PW:0] addr;
    logic [7:0]  data;
    logic        zero;
    logic        ngtv;
    logic        scry;
  } wr_req_t;

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// Writeback bus between the two requesters / decoder and the write arbiter.
//   ld_*      : load writeback request and its ready
//   alu_*     : ALU writeback request (with flags) and its ready
//   rd_addr*  : decoder read addresses, haz* : read-after-write hazard flags
//   rf_*      : register file write port (enable, address, data, flags)
// Modports: slave = the arbiter, master = requesters/decoder/register file side.
interface rf_wr_arbiter_if #(
  parameter int PW = rf_pkg::PW
);

  logic        ld_valid;
  logic        ld_ready;
  logic [PW:0] ld_addr;
  logic [7:0]  ld_data;

  logic        alu_valid;
  logic        alu_ready;
  logic [PW:0] alu_addr;
  logic [7:0]  alu_data;
  logic        alu_zero;
  logic        alu_ngtv;
  logic        alu_scry;

  logic [PW:0] rd_addrA;
  logic [PW:0] rd_addrB;
  logic        hazA;
  logic        hazB;

  logic        rf_wr_en;
  logic [PW:0] rf_wr_addr;
  logic [7:0]  rf_dat;
  logic        rf_zero;
  logic        rf_ngtv;
  logic        rf_scry;

  modport slave (
    input  ld_valid, ld_addr, ld_data,
    input  alu_valid, alu_addr, alu_data, alu_zero, alu_ngtv, alu_scry,
    input  rd_addrA, rd_addrB,
    output ld_ready, alu_ready, hazA, hazB,
    output rf_wr_en, rf_wr_addr, rf_dat, rf_zero, rf_ngtv, rf_scry
  );

  modport master (
    output ld_valid, ld_addr, ld_data,
    output alu_valid, alu_addr, alu_data, alu_zero, alu_ngtv, alu_scry,
    output rd_addrA, rd_addrB,
    input  ld_ready, alu_ready, hazA, hazB,
    input  rf_wr_en, rf_wr_addr, rf_dat, rf_zero, rf_ngtv, rf_scry
  );

endinterface

// File: rtl/rf_wr_arbiter_slot.sv
// One-entry pending slot for a writeback requester.
//   clk, reset : clock, synchronous active-high reset
//   in_valid   : request offered this cycle, in_req : its payload
//   grant      : this slot is being written to the register file this cycle
//   ready      : slot can accept (empty, or draining on this edge)
//   valid      : slot holds a pending write, req : the held payload
//   age        : slot has already waited across at least one edge
module rf_wr_slot
  import rf_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    in_valid,
  input  wr_req_t in_req,
  input  logic    grant,
  output logic    ready,
  output logic    valid,
  output logic    age,
  output wr_req_t req
);

  logic accept;

  // Ready depends only on slot state and reset, never on in_valid.
  assign ready  = !reset && (!valid || grant);
  assign accept = in_valid && ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      age   <= 1'b0;
    end else if (accept) begin
      valid <= 1'b1;
      age   <= 1'b0;
    end else if (grant) begin
      valid <= 1'b0;
      age   <= 1'b0;
    end else if (valid) begin
      // Survived an edge without being written: now older than any newcomer.
      age   <= 1'b1;
    end
  end

  // NOTE: the payload is deliberately not reset; it is only ever consumed
  // while valid is set, so a reset here would just add datapath fan-out.
  always_ff @(posedge clk) begin
    if (accept) req <= in_req;
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Arbitrates the single register-file write port between the load return
// (port 0) and the ALU result (port 1), keeps a shadow of the last ALU flags
// so load writes re-drive them unchanged, and flags read-after-write hazards.
//   clk, reset : clock, synchronous active-high reset
//   bus        : rf_wr_arbiter_if slave (requests, readies, hazards, rf_* write port)
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int PW = rf_pkg::PW
) (
  input  logic            clk,
  input  logic            reset,
  rf_wr_arbiter_if.slave  bus
);

  wr_req_t ld_in, alu_in, ld_q, alu_q, sel_q;
  logic    ld_v, alu_v, ld_age, alu_age;
  logic    both, same_addr, alu_first;
  logic    rr;
  logic [NUM_WR_PORTS-1:0] gnt;
  logic [PW:0] ld_addr_q, alu_addr_q;
  logic    sh_zero, sh_ngtv, sh_scry;

  assign ld_in  = '{addr: bus.ld_addr, data: bus.ld_data,
                    zero: 1'b0, ngtv: 1'b0, scry: 1'b0};
  assign alu_in = '{addr: bus.alu_addr, data: bus.alu_data,
                    zero: bus.alu_zero, ngtv: bus.alu_ngtv, scry: bus.alu_scry};

  rf_wr_slot u_ld_slot (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.ld_valid),
    .in_req   (ld_in),
    .grant    (gnt[PORT_LD]),
    .ready    (bus.ld_ready),
    .valid    (ld_v),
    .age      (ld_age),
    .req      (ld_q)
  );

  rf_wr_slot u_alu_slot (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.alu_valid),
    .in_req   (alu_in),
    .grant    (gnt[PORT_ALU]),
    .ready    (bus.alu_ready),
    .valid    (alu_v),
    .age      (alu_age),
    .req      (alu_q)
  );

  assign ld_addr_q  = ld_q.addr;
  assign alu_addr_q = alu_q.addr;
  assign both       = ld_v && alu_v;
  assign same_addr  = (ld_addr_q == alu_addr_q);

  // Same destination: strictly older slot first, ties to the load so the ALU
  // value lands last. Different destinations: round-robin pointer decides.
  assign alu_first = same_addr ? (alu_age && !ld_age) : (rr == 1'(PORT_ALU));

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    gnt = '0;
    if (!reset) begin
      if (both) begin
        if (alu_first) gnt[PORT_ALU] = 1'b1;
        else           gnt[PORT_LD]  = 1'b1;
      end else begin
        gnt[PORT_LD]  = ld_v;
        gnt[PORT_ALU] = alu_v;
      end
    end
  end

  assign sel_q = gnt[PORT_ALU] ? alu_q : ld_q;

  always_comb begin
    bus.rf_wr_en   = |gnt;
    bus.rf_wr_addr = '0;
    bus.rf_dat     = '0;
    bus.rf_zero    = sh_zero;
    bus.rf_ngtv    = sh_ngtv;
    bus.rf_scry    = sh_scry;
    if (|gnt) begin
      bus.rf_wr_addr = sel_q.addr;
      bus.rf_dat     = sel_q.data;
    end
    // Only ALU writes present fresh flags; loads re-drive the shadow.
    if (gnt[PORT_ALU]) begin
      bus.rf_zero = sel_q.zero;
      bus.rf_ngtv = sel_q.ngtv;
      bus.rf_scry = sel_q.scry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr      <= 1'(PORT_LD);
      sh_zero <= 1'b0;
      sh_ngtv <= 1'b0;
      sh_scry <= 1'b0;
    end else begin
      // After a contended grant the pointer favours the port that lost.
      if (both) rr <= gnt[PORT_LD] ? 1'(PORT_ALU) : 1'(PORT_LD);
      if (gnt[PORT_ALU]) begin
        sh_zero <= alu_q.zero;
        sh_ngtv <= alu_q.ngtv;
        sh_scry <= alu_q.scry;
      end
    end
  end

  // Only accepted (pending) writes are hazards; incoming requests are not.
  assign bus.hazA = (ld_v  && (ld_addr_q  == bus.rd_addrA)) ||
                    (alu_v && (alu_addr_q == bus.rd_addrA));
  assign bus.hazB = (ld_v  && (ld_addr_q  == bus.rd_addrB)) ||
                    (alu_v && (alu_addr_q == bus.rd_addrB));

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: port 0 (load / memory return) and port 1 (ALU result).
- Each port has a 1-entry pending slot. A round-robin grant drives the register file's write enable, address, data and flag inputs.
- The register file updates its zero/negative/shift-carry flags on every write. This block therefore keeps a shadow copy of the last ALU flags and re-drives it on load writes, so loads never corrupt the flags.
- Also provides read-after-write hazard indications to the decoder for both register read ports.

Parameters:
PW, 3, address pointer width; register addresses are PW+1 bits wide, matching the register file's wr_addr/rd_addr width

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
ld_valid  input  1  load writeback request
ld_ready  output  1  load slot can accept this cycle
ld_addr  input  PW+1  load destination register
ld_data  input  8  load data
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU slot can accept this cycle
alu_addr  input  PW+1  ALU destination register
alu_data  input  8  ALU result
alu_zero, alu_ngtv, alu_scry  input  1 each  ALU flag results
rd_addrA, rd_addrB  input  PW+1 each  decoder read addresses
hazA, hazB  output  1 each  read address matches a valid pending slot
rf_wr_en  output  1  register file write enable
rf_wr_addr  output  PW+1  register file write address
rf_dat  output  8  register file write data
rf_zero, rf_ngtv, rf_scry  output  1 each  flag values presented to the register file

Behaviour:
- Accept: a port accepts on a clock edge where valid && ready; the slot then captures addr and data (plus flags on the ALU port) and sets its valid bit.
- Ready: ready = !slot_valid || slot_granted_this_cycle. This allows back-to-back refill at full rate per port.
- Output timing: grant and all rf_* outputs are combinational from the slot state.
  - rf_wr_en=1 in any cycle in which at least one slot is valid.
  - The register file captures at the end of that cycle, and the granted slot clears on the same edge.
  - Accept-to-write latency is exactly 1 cycle when uncontended.
- Arbitration:
  - One valid slot: that slot is granted.
  - Both valid, different addresses: round-robin pointer rr (0 = load first); rr flips to the non-granted port after each contended grant.
  - Both valid, same address: the older slot is granted first (per-slot age bit; ties from same-cycle acceptance go to port 0, load). This guarantees the ALU write lands last.
- Flags:
  - ALU grant: rf_zero/ngtv/scry = the slot's flags, and the shadow flags update to those values.
  - Load grant: rf flag outputs = the shadow flags, and the shadow is unchanged.
- Idle outputs: rf_wr_en=0, rf_wr_addr=0, rf_dat=0, rf flag outputs = shadow.
- Hazards: hazA = (ld slot valid && ld_addr_q==rd_addrA) || (alu slot valid && alu_addr_q==rd_addrA). hazB is the same using rd_addrB. Incoming un-accepted requests are not compared.
- Reset (including mid-operation): both slots invalid, rr=0, age bits 0, shadow flags 000, ld_ready=alu_ready=1 while reset is low after release. While reset=1, ready=0 and no accepts occur. Pending data is discarded, not written.
- No combinational path from valid to ready.

Decomposition:
- Shared package rf_pkg: PW default, localparams NUM_WR_PORTS=2, PORT_LD=0, PORT_ALU=1, and a packed struct wr_req_t {addr, data, zero, ngtv, scry}.
- One natural sub-module: rf_wr_slot, a 1-entry holding register with valid, age and ready logic, instantiated once per port. The arbiter, shadow flags and hazard compare live in the top.

Test Plan:
- Single load: ld_valid=1, addr=3, data=8'hA5 at cycle 0 -> cycle 1 rf_wr_en=1, addr=3, dat=A5, flags=000 (post-reset shadow); then idle.
- ALU then load: ALU writes addr 2 with data 8'h00, zero=1 -> next cycle flags 100; then a load to addr 5 -> rf_zero=1 re-driven from the shadow.
- Contention: both ports valid every cycle for 4 cycles, distinct addresses -> grants alternate ld, alu, ld, alu; each ready deasserts while its slot waits; no request is lost.
- Same address, same cycle: ld addr=4 data=11, alu addr=4 data=22 -> write 11 then 22 on consecutive cycles; final reg4=22.
- Hazard: load to addr 6 pending, rd_addrA=6, rd_addrB=1 -> hazA=1, hazB=0; hazA drops the cycle after the slot clears.
- Reset mid-operation: both slots full, assert reset one cycle -> no rf write that cycle or after; slots empty, rr=0, shadow flags 000.
